// File: rtl/e_mdu_pkg.sv
// Shared MDU constants: operation encodings and default latencies.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for multiple cycles and need start.
  function automatic logic mdu_is_long(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath producing {hi,lo} and a div-by-zero flag.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  output logic [63:0] res,
  output logic        dz
);

  logic        [31:0] b_safe;
  logic signed [31:0] sa, sb;
  logic signed [31:0] sq, sr;
  logic signed [63:0] sa64, sb64;
  logic        [63:0] ua64, ub64;
  logic               ovf;

  // Division by zero leaves HI/LO untouched, so only the flag matters;
  // the divisor is forced to 1 to keep the divider free of X.
  assign dz     = mdu_is_div(op) && (B == 32'd0);
  assign b_safe = (B == 32'd0) ? 32'd1 : B;
  assign sa     = $signed(A);
  assign sb     = $signed(b_safe);
  assign sa64   = {{32{A[31]}}, A};
  assign sb64   = {{32{B[31]}}, B};
  assign ua64   = {32'd0, A};
  assign ub64   = {32'd0, B};

  // MIN / -1 overflows; the MIPS result is quotient MIN, remainder 0.
  assign ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign sq  = ovf ? $signed(32'h8000_0000) : sa / sb;
  assign sr  = ovf ? $signed(32'd0)         : sa % sb;

  // Select the result for the requested operation; {hi,lo} ordering.
  always_comb begin
    res = 64'd0;
    case (op)
      MDU_MULT:  res = sa64 * sb64;
      MDU_MULTU: res = ua64 * ub64;
      MDU_DIV:   res = {sr, sq};
      MDU_DIVU:  res = {A % b_safe, A / b_safe};
      default:   res = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, countdown busy timer, mf/mt access.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] MDUout
);

  logic [31:0] hi, lo;
  logic [31:0] hi_n, lo_n;
  logic        dz_n;
  logic [3:0]  cnt;
  logic [63:0] res;
  logic        dz;

  e_mdu_calc u_calc (
    .A   (A),
    .B   (B),
    .op  (MDUop),
    .res (res),
    .dz  (dz)
  );

  // Busy is exactly "counter running"; it rises the edge after start.
  assign busy = (cnt != 4'd0);

  // Accept/countdown/commit; mt writes only when idle, starts while busy dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      hi_n <= 32'd0;
      lo_n <= 32'd0;
      dz_n <= 1'b0;
      cnt  <= 4'd0;
    end else if (cnt == 4'd0) begin
      if (start && mdu_is_long(MDUop)) begin
        hi_n <= res[63:32];
        lo_n <= res[31:0];
        dz_n <= dz;
        cnt  <= mdu_is_div(MDUop) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (MDUop == MDU_MTHI) begin
        hi <= A;
      end else if (MDUop == MDU_MTLO) begin
        lo <= A;
      end
    end else if (cnt == 4'd1) begin
      cnt <= 4'd0;
      if (!dz_n) begin
        hi <= hi_n;
        lo <= lo_n;
      end
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

  // Zero-latency read port for mfhi/mflo.
  always_comb begin
    MDUout = 32'd0;
    case (MDUop)
      MDU_MFHI: MDUout = hi;
      MDU_MFLO: MDUout = lo;
      default:  MDUout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus queues expectations, monitors compare.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDUop;
  logic        start;
  logic        busy;
  logic [31:0] MDUout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_rd[$];
  int          exp_len[$];
  int          blen = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .MDUop  (MDUop),
    .start  (start),
    .busy   (busy),
    .MDUout (MDUout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Read monitor: every mfhi/mflo slot is compared against the queued value.
  always @(negedge clk) begin
    if (reset && (MDUop == MDU_MFHI || MDUop == MDU_MFLO)) begin
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got %h expected nothing queued", MDUout);
      end else begin
        logic [31:0] e;
        e = exp_rd.pop_front();
        if (MDUout !== e) begin
          failures++;
          $display("FAIL rd_%s: got %h expected %h",
                   (MDUop == MDU_MFHI) ? "hi" : "lo", MDUout, e);
        end
      end
    end
  end

  // Busy monitor: measures each busy pulse and compares against queued length.
  always @(negedge clk) begin
    if (!reset) begin
      blen = 0;
    end else if (busy === 1'b1) begin
      blen++;
    end else if (blen != 0) begin
      checks++;
      if (exp_len.size() == 0) begin
        failures++;
        $display("FAIL busy_unexpected: got %0d cycles expected none", blen);
      end else begin
        int e;
        e = exp_len.pop_front();
        if (blen != e) begin
          failures++;
          $display("FAIL busy_len: got %0d cycles expected %0d", blen, e);
        end
      end
      blen = 0;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic st);
    @(posedge clk);
    #2;
    MDUop = op;
    A     = a;
    B     = b;
    start = st;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle: got busy stuck expected release within 40 cycles");
  endtask

  task automatic read(input logic [31:0] ehi, input logic [31:0] elo);
    exp_rd.push_back(ehi);
    issue(MDU_MFHI, 32'd0, 32'd0, 1'b0);
    exp_rd.push_back(elo);
    issue(MDU_MFLO, 32'd0, 32'd0, 1'b0);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int len, input logic [31:0] ehi, input logic [31:0] elo);
    exp_len.push_back(len);
    issue(op, a, b, 1'b1);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle();
    read(ehi, elo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    A = 32'd0; B = 32'd0; MDUop = MDU_NONE; start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_out", MDUout, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    read(32'd0, 32'd0);

    run_op(MDU_MULT,  32'hFFFF_FFFF, 32'd2, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(MDU_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 32'h0000_0000);
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    // mthi/mtlo then divide by zero: HI/LO must survive.
    issue(MDU_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'h0000_5678, 32'd0, 1'b0);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
    read(32'h0000_1234, 32'h0000_5678);
    run_op(MDU_DIVU, 32'd7, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);

    // Signed divide by zero with an mthi attempted mid-operation.
    exp_len.push_back(10);
    issue(MDU_DIV, 32'd5, 32'd0, 1'b1);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
    issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle();
    read(32'h0000_1234, 32'h0000_5678);

    // Second start during busy cycle 2 is dropped.
    exp_len.push_back(5);
    issue(MDU_MULT, 32'd3, 32'd4, 1'b1);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
    issue(MDU_MULT, 32'd5, 32'd6, 1'b1);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
    wait_idle();
    read(32'd0, 32'd12);

    // Restore nonzero HI/LO so the reset clearing is visible.
    issue(MDU_MTHI, 32'h0000_00AA, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'h0000_00BB, 32'd0, 1'b0);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);

    // Reset during busy cycle 3 of a div: immediate clear, no late commit.
    issue(MDU_DIV, 32'd100, 32'd7, 1'b1);
    issue(MDU_NONE, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check32("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    MDUop = MDU_MFHI;
    #1;
    check32("midreset_busy", {31'd0, busy}, 32'd0);
    check32("midreset_hi", MDUout, 32'd0);
    MDUop = MDU_MFLO;
    #1;
    check32("midreset_lo", MDUout, 32'd0);
    MDUop = MDU_NONE;
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    check32("post_reset_busy", {31'd0, busy}, 32'd0);
    read(32'd0, 32'd0);

    repeat (3) @(posedge clk);
    check32("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check32("len_queue_empty", 32'(exp_len.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
